// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: pipeline-side hazard inputs and controller-side stall/flush/debug outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  branch_taken;
  logic                  dmem_busy;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  ex_mem_hold;
  logic [1:0]            state_o;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd, branch_taken, dmem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, state_o, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd, branch_taken, dmem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, state_o, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, EX-resolved
// branch redirects with an extra IF/ID flush window, data-memory waits, perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int unsigned RC_W = 3;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic flush_evt;
  logic pc_write_c;
  logic if_id_write_c;
  logic if_id_flush_c;
  logic id_ex_flush_c;
  logic ex_mem_hold_c;

  // Load-use: EX load targets a non-zero register that ID actually reads.
  always_comb begin
    lu = hz.ex_mem_read && (hz.ex_rd != REG_ADDR_W'(0)) &&
         ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
          (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
  end

  // Next-state and Mealy outputs; MEM_WAIT falls back to RUN rules once memory completes.
  always_comb begin
    state_d       = state_q;
    rc_d          = rc_q;
    flush_evt     = 1'b0;
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    ex_mem_hold_c = 1'b0;

    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (hz.dmem_busy) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          ex_mem_hold_c = 1'b1;
          state_d       = ST_MEM_WAIT;
        end else if (hz.branch_taken) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          flush_evt     = 1'b1;
          if (BR_PENALTY != 0) begin
            state_d = ST_REDIRECT;
            rc_d    = RC_W'(BR_PENALTY);
          end else begin
            state_d = ST_RUN;
          end
        end else if (lu) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          id_ex_flush_c = 1'b1;
          state_d       = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_REDIRECT: begin
        if (hz.dmem_busy) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          ex_mem_hold_c = 1'b1;
        end else if (hz.branch_taken) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          flush_evt     = 1'b1;
          rc_d          = RC_W'(BR_PENALTY);
        end else begin
          if_id_flush_c = 1'b1;
          rc_d          = rc_q - RC_W'(1);
          if (rc_q <= RC_W'(1)) begin
            state_d = ST_RUN;
            rc_d    = '0;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
        rc_d    = '0;
      end
    endcase
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_c && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt && !(&flush_cnt_q))   flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      rc_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset forces the free-running enables so the pipeline drains cleanly while held.
  assign hz.pc_write    = reset | pc_write_c;
  assign hz.if_id_write = reset | if_id_write_c;
  assign hz.if_id_flush = ~reset & if_id_flush_c;
  assign hz.id_ex_flush = ~reset & id_ex_flush_c;
  assign hz.ex_mem_hold = ~reset & ex_mem_hold_c;
  assign hz.state_o     = state_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipelined RISC-V core.
- Decides every cycle whether the PC and IF/ID register advance, stall or flush, and whether bubbles are injected into ID/EX and EX/MEM.
- Handles load-use stalls, taken-branch redirects (resolved in EX) with a configurable extra flush window, and multi-cycle data-memory waits.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- REG_ADDR_W, 5, width of register specifiers.
- BR_PENALTY, 1, extra cycles (0..7) IF/ID stays flushed after a redirect, covering instruction-memory fetch latency.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID.
- id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- dmem_busy  in  1  data memory has not completed the MEM-stage access.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID synchronous clear.
- id_ex_flush  out  1  ID/EX clear (bubble).
- ex_mem_hold  out  1  hold EX/MEM and MEM/WB.
- state_o  out  2  current FSM state (debug).
- stall_cnt  out  CNT_W  cycles with pc_write=0.
- flush_cnt  out  CNT_W  redirect events accepted.

Behaviour:
- Outputs are combinational from state plus current inputs (Mealy), so the pipeline registers act on the same rising edge.
- FSM states: RUN=0, REDIRECT=1, MEM_WAIT=2.
- Reset (async) sets state=RUN, counters=0 and the redirect counter rc=0. During reset: pc_write=1, if_id_write=1, all flush/hold outputs=0.
- Load-use hazard: lu = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority within a cycle: dmem_busy > branch_taken > lu.
- RUN, dmem_busy=1: pc_write=0, if_id_write=0, ex_mem_hold=1, id_ex_flush=0. Next state MEM_WAIT. A coincident branch_taken is ignored this cycle; EX holds, so it re-presents the branch later.
- RUN, branch_taken=1: pc_write=1 (loads target), if_id_flush=1, id_ex_flush=1. flush_cnt += 1.
  - If BR_PENALTY>0: next state REDIRECT, rc=BR_PENALTY.
  - Otherwise stay in RUN.
- RUN, lu=1: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble per hazard occurrence. Stay in RUN.
- RUN, otherwise: pc_write=1, if_id_write=1, all flush/hold outputs=0.
- REDIRECT:
  - Outputs: pc_write=1, if_id_flush=1, id_ex_flush=0, rc-=1. Go to RUN when rc reaches 0 (rc==1 on entry to the cycle).
  - dmem_busy in REDIRECT: hold everything and freeze rc; state stays REDIRECT.
  - branch_taken in REDIRECT: treated as a new redirect. Reload rc=BR_PENALTY, assert id_ex_flush, flush_cnt += 1.
- MEM_WAIT: pc_write=0, if_id_write=0, ex_mem_hold=1. When dmem_busy falls, this cycle's outputs follow RUN rules with the current inputs, and next state is RUN (or REDIRECT per the RUN rules).
- stall_cnt increments in every cycle with pc_write=0. Both counters saturate at all-ones.
- Reset asserted mid-REDIRECT or mid-MEM_WAIT returns immediately to RUN with rc=0.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5), ID reads rs2=5 with id_use_rs2=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; next cycle normal; stall_cnt=1.
- ex_rd=0 with a matching rs1=0 load -> no stall, all enables 1.
- branch_taken pulse, BR_PENALTY=1 -> cycle 0: if_id_flush=1, id_ex_flush=1; cycle 1: if_id_flush=1, state=REDIRECT; cycle 2: RUN; flush_cnt=1.
- dmem_busy high for 3 cycles together with branch_taken and lu -> 3 cycles of ex_mem_hold=1, pc_write=0, no flush; on release the branch is honoured; stall_cnt=3.
- Second branch_taken during REDIRECT -> rc reloads, flush_cnt=2, REDIRECT extended by BR_PENALTY cycles.
- reset asserted asynchronously in MEM_WAIT -> state_o=0, counters=0, pc_write=1 before the next clock edge.
